// File: rtl/scan_select_gen_if.sv
`default_nettype none
// ============================================================
// Module : scan_select_gen_if
// Control/data bundle between a digit source and the scan generator.
// Rev    : 1.0
// ============================================================
interface scan_select_gen_if;
  logic        en;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  blank_in;
  logic        sel_a;
  logic        sel_b;
  logic [3:0]  digit_out;
  logic        blank;
  logic        frame_done;
  logic        pending;

  modport master (
    output en, load, digits_in, blank_in,
    input  sel_a, sel_b, digit_out, blank, frame_done, pending
  );

  modport slave (
    input  en, load, digits_in, blank_in,
    output sel_a, sel_b, digit_out, blank, frame_done, pending
  );
endinterface
`default_nettype wire

// File: rtl/scan_select_gen.sv
`default_nettype none
// ============================================================
// Module : scan_select_gen
// Scan/select driver for a 4-digit multiplexed display with frame-aligned digit updates.
// Rev    : 1.0
// ============================================================
module scan_select_gen #(
  parameter int DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  scan_select_gen_if.slave io_scan
);

  localparam int                 c_CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_PRESC_MAX = c_CNT_W'(DIV - 1);

  logic [c_CNT_W-1:0] r_presc;
  logic [1:0]         r_idx;
  logic               r_fd;
  logic [15:0]        r_sh_d;
  logic [3:0]         r_sh_b;
  logic               r_pend;
  logic [15:0]        r_act_d;
  logic [3:0]         r_act_b;

  logic w_tick;
  logic w_wrap;
  logic w_apply;

  assign w_tick  = io_scan.en && (r_presc == c_PRESC_MAX);
  assign w_wrap  = w_tick && (r_idx == 2'd3);
  assign w_apply = w_wrap && r_pend;

  // Prescaler and digit index only move while scanning is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (io_scan.en) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fd <= 1'b0;
    end else begin
      r_fd <= w_wrap;
    end
  end

  // A load in the wrap cycle still lets the older shadow reach the active set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_d <= 16'h0000;
      r_sh_b <= 4'h0;
      r_pend <= 1'b0;
    end else if (io_scan.load) begin
      r_sh_d <= io_scan.digits_in;
      r_sh_b <= io_scan.blank_in;
      r_pend <= 1'b1;
    end else if (w_apply) begin
      r_pend <= 1'b0;
    end
  end

  // Display starts dark until the first frame-aligned update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_d <= 16'h0000;
      r_act_b <= 4'hF;
    end else if (w_apply) begin
      r_act_d <= r_sh_d;
      r_act_b <= r_sh_b;
    end
  end

  assign io_scan.sel_a      = r_idx[1];
  assign io_scan.sel_b      = r_idx[0];
  assign io_scan.digit_out  = r_act_d[{r_idx, 2'b00} +: 4];
  assign io_scan.blank      = r_act_b[r_idx];
  assign io_scan.frame_done = r_fd;
  assign io_scan.pending    = r_pend;

  a_fd_at_idx0 : assert property (@(posedge clk) disable iff (!rst_n)
    r_fd |-> (r_idx == 2'd0));

  a_fd_single : assert property (@(posedge clk) disable iff (!rst_n)
    r_fd |=> !r_fd);

  a_no_x : assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({io_scan.sel_a, io_scan.sel_b, io_scan.digit_out,
                 io_scan.blank, io_scan.frame_done, io_scan.pending}));

endmodule
`default_nettype wire
